// File: rtl/tiny16_intc_pkg.sv
// Shared definitions for the tiny16 interrupt controller: register offsets,
// FSM state encoding and STATUS bit positions.
package tiny16_intc_pkg;

   localparam logic [2:0] REG_PEND   = 3'd0;
   localparam logic [2:0] REG_SET    = 3'd1;
   localparam logic [2:0] REG_ENABLE = 3'd2;
   localparam logic [2:0] REG_EDGE   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int STATUS_SERVICE_BIT = 15;
   localparam int STATUS_REQUEST_BIT = 14;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } intc_state_e;

endpackage

// File: rtl/tiny16_intc_sync.sv
// One request line: two-flop synchroniser plus a history flop, giving the
// synchronised level and a single-cycle rising-edge pulse.
module tiny16_intc_sync (
   input  logic clk,
   input  logic nreset,
   input  logic irq,
   output logic level,
   output logic rise
);

   logic s1_q, s2_q, s3_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= irq;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/tiny16_intc.sv
// Memory-mapped interrupt controller for the tiny16 core: latches synchronised
// requests, applies enable/edge selection with fixed priority, and hands one
// frozen vector to the core per acknowledge/return cycle.
module tiny16_intc
   import tiny16_intc_pkg::*;
#(
   parameter int          INTERRUPT_BITS = 2,
   parameter int          NUM_IRQ        = 3,
   parameter logic [15:0] BASE_ADDR      = 16'hFFF0
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic [NUM_IRQ-1:0]        irq,
   input  logic [15:0]               address,
   input  logic [15:0]               wdata,
   output logic [15:0]               rdata,
   input  logic                      nrd,
   input  logic                      nwr,
   input  logic                      in_interrupt,
   output logic [INTERRUPT_BITS-1:0] interrupt
);

   logic [NUM_IRQ-1:0]        level, rise;
   logic [NUM_IRQ-1:0]        pending_q, pending_d;
   logic [NUM_IRQ-1:0]        enable_q, edge_q;
   logic [NUM_IRQ-1:0]        eligible, pend_clr, set_req;
   logic [INTERRUPT_BITS-1:0] active_q, interrupt_q, next_vector;
   intc_state_e               state_q;
   logic                      hit, wr_en, rd_en, ack;
   logic [2:0]                offset;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      tiny16_intc_sync u_sync (
         .clk    (clk),
         .nreset (nreset),
         .irq    (irq[g]),
         .level  (level[g]),
         .rise   (rise[g])
      );
   end

   // Data bits above the last source have no register behind them.
   if (NUM_IRQ < 16) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^wdata[15:NUM_IRQ];
   end

   assign hit      = (address[15:3] == BASE_ADDR[15:3]);
   assign offset   = address[2:0];
   assign wr_en    = hit & ~nwr;
   assign rd_en    = hit & ~nrd;
   assign pend_clr = (wr_en && offset == REG_PEND) ? wdata[NUM_IRQ-1:0] : '0;
   assign set_req  = (wr_en && offset == REG_SET)  ? wdata[NUM_IRQ-1:0] : '0;
   assign ack      = (state_q == REQUEST) && in_interrupt;
   assign eligible = pending_q & enable_q;

   // NOTE: every combinational output gets a default first so no path through
   // the block leaves it unassigned and infers a latch.
   always_comb begin
      next_vector = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) next_vector = INTERRUPT_BITS'(i + 1);
      end
   end

   // Edge bits: a set in the same cycle beats any clear.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (edge_q[i]) begin
            if (pend_clr[i] || (ack && active_q == INTERRUPT_BITS'(i + 1)))
               pending_d[i] = 1'b0;
            if (rise[i] || set_req[i])
               pending_d[i] = 1'b1;
         end else begin
            pending_d[i] = level[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         pending_q <= '0;
         enable_q  <= '0;
         edge_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (wr_en && offset == REG_ENABLE) enable_q <= wdata[NUM_IRQ-1:0];
         if (wr_en && offset == REG_EDGE)   edge_q   <= wdata[NUM_IRQ-1:0];
      end
   end

   // The vector is captured once on entry to REQUEST and held until acknowledge.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q     <= IDLE;
         active_q    <= '0;
         interrupt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|eligible && !in_interrupt) begin
                  active_q    <= next_vector;
                  interrupt_q <= next_vector;
                  state_q     <= REQUEST;
               end
            end
            REQUEST: begin
               if (in_interrupt) begin
                  interrupt_q <= '0;
                  state_q     <= SERVICE;
               end
            end
            SERVICE: begin
               if (!in_interrupt) state_q <= IDLE;
            end
            default: begin
               interrupt_q <= '0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign interrupt = interrupt_q;

   always_comb begin
      rdata = '0;
      if (rd_en) begin
         case (offset)
            REG_PEND:   rdata[NUM_IRQ-1:0] = pending_q;
            REG_ENABLE: rdata[NUM_IRQ-1:0] = enable_q;
            REG_EDGE:   rdata[NUM_IRQ-1:0] = edge_q;
            REG_STATUS: begin
               rdata[STATUS_SERVICE_BIT]   = (state_q == SERVICE);
               rdata[STATUS_REQUEST_BIT]   = (state_q == REQUEST);
               rdata[INTERRUPT_BITS-1:0]   = active_q;
            end
            default:    rdata = '0;
         endcase
      end
   end

endmodule
